// File: rtl/silu_pkg.sv
// Shared definitions for the SiLU forward/backward datapaths: FSM encodings,
// sizing helpers and fixed-point round/saturate arithmetic.
package silu_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOOK  = 3'd1;
  localparam logic [2:0] ST_MUL_T = 3'd2;
  localparam logic [2:0] ST_MUL_U = 3'd3;
  localparam logic [2:0] ST_MUL_G = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic int range_q(input int x_min, input int x_max);
    return x_max - x_min;
  endfunction

  function automatic int acc_width(input int width);
    return 2 * width + 2;
  endfunction

  // Round half away from zero, then drop frac bits; products must fit in 62 bits.
  function automatic logic signed [63:0] rnd(input logic signed [63:0] p, input int frac);
    logic signed [63:0] mag;
    logic signed [63:0] half;
    logic signed [63:0] r;
    half = 64'sd1 <<< (frac - 1);
    mag  = (p < 64'sd0) ? -p : p;
    r    = (mag + half) >>> frac;
    return (p < 64'sd0) ? -r : r;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/silu_sigmoid_lut.sv
// Registered-read sigmoid ROM over [X_MIN_Q, X_MAX_Q]; contents are built at
// elaboration so the same block can serve the forward SiLU path.
module silu_sigmoid_lut
  import silu_pkg::*;
#(
  parameter int FRAC     = 8,
  parameter int LUT_SIZE = 1024,
  parameter int X_MIN_Q  = -(32'sd8 <<< FRAC),
  parameter int X_MAX_Q  = (32'sd8 <<< FRAC),
  parameter int IDX_W    = $clog2(LUT_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  output logic [FRAC:0]    s_q
);

  localparam int ONE = 1 << FRAC;

  // e^|x| by power series keeps the table independent of tool math support.
  function automatic int sigmoid_entry(input int i);
    real    xr;
    real    ax;
    real    term;
    real    e;
    real    s;
    longint off;
    off  = (longint'(i) * longint'(range_q(X_MIN_Q, X_MAX_Q))) / longint'(LUT_SIZE - 1);
    xr   = real'(longint'(X_MIN_Q) + off) / real'(ONE);
    ax   = (xr < 0.0) ? -xr : xr;
    term = 1.0;
    e    = 1.0;
    for (int k = 1; k <= 48; k++) begin
      term = term * ax / real'(k);
      e    = e + term;
    end
    s = (xr < 0.0) ? 1.0 / (1.0 + e) : e / (1.0 + e);
    return $rtoi(s * real'(ONE) + 0.5);
  endfunction

  logic [FRAC:0] rom [LUT_SIZE];
  logic [FRAC:0] s_d;

  for (genvar i = 0; i < LUT_SIZE; i++) begin : g_rom
    localparam int ENTRY = sigmoid_entry(i);
    assign rom[i] = (FRAC + 1)'(ENTRY);
  end

  // ROM address decode.
  always_comb begin
    s_d = rom[idx];
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/silu_backward.sv
// SiLU backward pass: grad_in = grad_out * s*(1 + x*(1-s)), evaluated one lane
// at a time through a single shared WIDTH x (WIDTH+1) multiplier.
module silu_backward
  import silu_pkg::*;
#(
  parameter int DIM      = 1,
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int LUT_SIZE = 1024,
  parameter int X_MIN_Q  = -(32'sd8 <<< FRAC),
  parameter int X_MAX_Q  = (32'sd8 <<< FRAC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIM*WIDTH-1:0] x_vec,
  input  logic [DIM*WIDTH-1:0] grad_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM*WIDTH-1:0] grad_in_vec
);

  localparam int ONE    = 1 << FRAC;
  localparam int ACC_W  = acc_width(WIDTH);
  localparam int IDX_W  = $clog2(LUT_SIZE);
  localparam int LANE_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int NUM_W  = WIDTH + IDX_W + 4;
  localparam int RANGE  = range_q(X_MIN_Q, X_MAX_Q);
  localparam logic signed [WIDTH:0] ONE_W = (WIDTH + 1)'(ONE);

  logic [2:0]              state_q, state_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [DIM*WIDTH-1:0]    x_q, x_d, gv_q, gv_d, res_q, res_d, grad_in_q, grad_in_d;
  logic signed [WIDTH-1:0] t_q, t_d;
  logic signed [WIDTH:0]   dsum_q, dsum_d;
  logic                    in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic signed [WIDTH-1:0] x_lane_s, g_lane_s, xc_s, mul_a_s, mul_res_s;
  logic signed [WIDTH+1:0] off_s;
  logic signed [WIDTH:0]   mul_b_s, s_ext_s;
  logic signed [ACC_W-1:0] prod_s;
  logic [NUM_W-1:0]        num_s, quo_s;
  logic [IDX_W-1:0]        idx_s;
  logic [FRAC:0]           s_q;

  assign x_lane_s = $signed(x_q[lane_q*WIDTH +: WIDTH]);
  assign g_lane_s = $signed(gv_q[lane_q*WIDTH +: WIDTH]);
  assign s_ext_s  = $signed({{(WIDTH - FRAC){1'b0}}, s_q});

  // Clamp x into the table span and scale it to a ROM index.
  always_comb begin
    if (32'(x_lane_s) < X_MIN_Q) begin
      xc_s = WIDTH'(X_MIN_Q);
    end else if (32'(x_lane_s) > X_MAX_Q) begin
      xc_s = WIDTH'(X_MAX_Q);
    end else begin
      xc_s = x_lane_s;
    end
    off_s = (WIDTH + 2)'(xc_s) - (WIDTH + 2)'(X_MIN_Q);
    num_s = NUM_W'(off_s) * NUM_W'(LUT_SIZE - 1);
    quo_s = num_s / NUM_W'(RANGE);
    if (quo_s > NUM_W'(LUT_SIZE - 1)) begin
      idx_s = IDX_W'(LUT_SIZE - 1);
    end else begin
      idx_s = quo_s[IDX_W-1:0];
    end
  end

  silu_sigmoid_lut #(
    .FRAC     (FRAC),
    .LUT_SIZE (LUT_SIZE),
    .X_MIN_Q  (X_MIN_Q),
    .X_MAX_Q  (X_MAX_Q),
    .IDX_W    (IDX_W)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (idx_s),
    .s_q   (s_q)
  );

  // Shared multiplier operand select; t, u and g all go through rnd then sat.
  always_comb begin
    case (state_q)
      ST_MUL_T: begin
        mul_a_s = x_lane_s;
        mul_b_s = ONE_W - s_ext_s;
      end
      ST_MUL_U: begin
        mul_a_s = t_q;
        mul_b_s = s_ext_s;
      end
      ST_MUL_G: begin
        mul_a_s = g_lane_s;
        mul_b_s = dsum_q;
      end
      default: begin
        mul_a_s = '0;
        mul_b_s = '0;
      end
    endcase
    prod_s    = ACC_W'(mul_a_s) * ACC_W'(mul_b_s);
    mul_res_s = WIDTH'(sat(rnd(64'(prod_s), FRAC), WIDTH));
  end

  // Sequencing: capture, per-lane LOOK/MUL_T/MUL_U/MUL_G, then hold in DONE.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    x_d         = x_q;
    gv_d        = gv_q;
    t_d         = t_q;
    dsum_d      = dsum_q;
    res_d       = res_q;
    grad_in_d   = grad_in_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = x_vec;
          gv_d    = grad_vec;
          lane_d  = '0;
          state_d = ST_LOOK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOK:  state_d = ST_MUL_T;
      ST_MUL_T: begin
        t_d     = mul_res_s;
        state_d = ST_MUL_U;
      end
      ST_MUL_U: begin
        dsum_d  = s_ext_s + $signed({mul_res_s[WIDTH-1], mul_res_s});
        state_d = ST_MUL_G;
      end
      ST_MUL_G: begin
        res_d[lane_q*WIDTH +: WIDTH] = mul_res_s;
        if (lane_q == LANE_W'(DIM - 1)) begin
          state_d = ST_DONE;
        end else begin
          lane_d  = lane_q + LANE_W'(1);
          state_d = ST_LOOK;
        end
      end
      ST_DONE: begin
        // One extra cycle publishes the finished vector into the output register.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          grad_in_d   = res_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      x_q         <= '0;
      gv_q        <= '0;
      t_q         <= '0;
      dsum_q      <= '0;
      res_q       <= '0;
      grad_in_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      x_q         <= x_d;
      gv_q        <= gv_d;
      t_q         <= t_d;
      dsum_q      <= dsum_d;
      res_q       <= res_d;
      grad_in_q   <= grad_in_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign grad_in_vec = grad_in_q;

endmodule

// File: tb/tb_silu_backward.sv
// Randomized self-checking bench for silu_backward (Q8.8), with a scalar and a
// four-lane instance checked against a real-arithmetic reference model.
module tb_silu_backward;

  localparam longint ONE_Q = 256;
  localparam longint XMIN  = -2048;
  localparam longint XMAX  = 2048;
  localparam longint LUT_N = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               iv1 = 1'b0, or1 = 1'b0, ir1, ov1;
  logic [15:0]        x1 = '0, g1 = '0;
  logic signed [15:0] gi1;
  logic               iv4 = 1'b0, or4 = 1'b0, ir4, ov4;
  logic [63:0]        x4 = '0, g4 = '0, gi4;

  int n_checks = 0;
  int n_fail   = 0;

  silu_backward #(.DIM(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .x_vec(x1),
    .grad_vec(g1), .out_valid(ov1), .out_ready(or1), .grad_in_vec(gi1)
  );

  silu_backward #(.DIM(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .x_vec(x4),
    .grad_vec(g4), .out_valid(ov4), .out_ready(or4), .grad_in_vec(gi4)
  );

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_sat(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint ref_rnd(longint p);
    if (p < 0) return -(((-p) + ONE_Q / 2) / ONE_Q);
    return (p + ONE_Q / 2) / ONE_Q;
  endfunction

  function automatic longint ref_sig(longint x);
    longint xc, idx, xi;
    xc  = (x < XMIN) ? XMIN : ((x > XMAX) ? XMAX : x);
    idx = ((xc - XMIN) * (LUT_N - 1)) / (XMAX - XMIN);
    if (idx > LUT_N - 1) idx = LUT_N - 1;
    xi  = XMIN + (idx * (XMAX - XMIN)) / (LUT_N - 1);
    return $rtoi(256.0 / (1.0 + $exp(-real'(xi) / 256.0)) + 0.5);
  endfunction

  function automatic longint ref_grad(longint x, longint g);
    longint s, t, u;
    s = ref_sig(x);
    t = ref_sat(ref_rnd(x * (ONE_Q - s)));
    u = ref_sat(ref_rnd(t * s));
    return ref_sat(ref_rnd(g * (s + u)));
  endfunction

  task automatic run1(input logic signed [15:0] x, input logic signed [15:0] g,
                      output logic signed [15:0] res, output int lat);
    check("in_ready_idle", ir1, 1);
    x1 = x; g1 = g; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; x1 = 16'($urandom); g1 = 16'($urandom);
    lat = 0;
    while (!ov1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    res = gi1;
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    check("in_ready_after_done", ir1, 1);
    check("out_valid_after_done", ov1, 0);
  endtask

  logic signed [15:0] res;
  int                 lat;
  longint             xs [4];
  longint             gs [4];
  logic [63:0]        snap;

  initial begin
    #12;
    check("rst_in_ready1", ir1, 1);
    check("rst_out_valid1", ov1, 0);
    check("rst_grad1", gi1, 0);
    check("rst_in_ready4", ir4, 1);
    check("rst_out_valid4", ov4, 0);
    check("rst_grad4", gi4, 0);
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;

    run1(16'sd0, 16'sd256, res, lat);
    check("latency_x0", lat, 5);
    check("grad_x0", res, ref_grad(0, 256));
    run1(16'sd2048, 16'sd256, res, lat);
    check("grad_xmax", res, 256);
    run1(-16'sd2048, 16'sd256, res, lat);
    check("grad_xmin", res, 0);
    run1(16'sd5120, 16'sd256, res, lat);
    check("grad_clamp_hi", res, 256);
    run1(-16'sd5120, 16'sd256, res, lat);
    check("grad_clamp_lo", res, 0);
    run1(16'sd614, 16'sd32767, res, lat);
    check("grad_sat_pos", res, 32767);
    run1(16'sd614, -16'sd32768, res, lat);
    check("grad_sat_neg", res, -32768);

    for (int i = 0; i < 30; i++) begin
      logic signed [15:0] xr, gr;
      xr = (i % 2 == 0) ? 16'($urandom) : 16'($signed($urandom_range(32'd4400)) - 32'sd2200);
      gr = 16'($urandom);
      run1(xr, gr, res, lat);
      check("latency_rand", lat, 5);
      check("grad_rand", res, ref_grad(xr, gr));
    end

    // Four-lane vector with out_ready held off and in_valid noise while busy.
    xs[0] = 614; gs[0] = 32767;
    for (int j = 1; j < 4; j++) begin
      xs[j] = $signed(16'($urandom));
      gs[j] = $signed(16'($urandom));
    end
    if ((xs[1] & 1) == 0) xs[1] = -100;
    for (int j = 0; j < 4; j++) begin
      x4[j*16 +: 16] = 16'(xs[j]);
      g4[j*16 +: 16] = 16'(gs[j]);
    end
    iv4 = 1'b1;
    @(posedge clk); #1;
    x4 = {$urandom, $urandom}; g4 = {$urandom, $urandom};
    lat = 0;
    while (!ov4 && lat < 200) begin
      check("in_ready_busy4", ir4, 0);
      @(posedge clk); #1; lat++;
      if (lat == 6) iv4 = 1'b0;
    end
    check("latency_dim4", lat, 17);
    snap = gi4;
    for (int j = 0; j < 4; j++) check("grad_lane4", $signed(gi4[j*16 +: 16]), ref_grad(xs[j], gs[j]));
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("hold_valid4", ov4, 1);
      check("hold_in_ready4", ir4, 0);
      check("hold_data4", gi4, snap);
    end
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    check("done_in_ready4", ir4, 1);
    check("done_valid4", ov4, 0);

    // Reset in MUL_U aborts the vector; the next one must still be correct.
    run1(16'sd614, 16'sd32767, res, lat);
    x1 = -16'sd614; g1 = 16'sd1000; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", ov1, 0);
    check("abort_grad", gi1, 0);
    check("abort_in_ready", ir1, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run1(-16'sd614, 16'sd1000, res, lat);
    check("post_reset_latency", lat, 5);
    check("post_reset_grad", res, ref_grad(-614, 1000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
